// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the VGA-adapter write port between snake, food and a screen-clear sweeper.
// Latency: an accepted pixel, or a sweep pixel, reaches vga_* with vga_plot=1 on the next clock edge.
// Backpressure: requesters hold req until gnt; no grants while clearing; at most one pixel per cycle.
// Optional build macro PLOT_BORDER_EN: the clear sweep paints edge pixels 3'b111 to draw the arena wall.
module plot_arbiter #(
   parameter int         SCREEN_W  = 160,
   parameter int         SCREEN_H  = 120,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_start,
   output logic       clear_done,
   input  logic       snake_req,
   input  logic [7:0] snake_x,
   input  logic [6:0] snake_y,
   input  logic [2:0] snake_colour,
   output logic       snake_gnt,
   input  logic       food_req,
   input  logic [7:0] food_x,
   input  logic [6:0] food_y,
   input  logic [2:0] food_colour,
   output logic       food_gnt,
   output logic       busy,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   typedef enum logic {ST_RUN, ST_CLEAR} state_t;
   typedef enum logic {GRANT_SNAKE, GRANT_FOOD} grant_t;

   localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

   state_t     state_q, state_d;
   grant_t     last_grant_q, last_grant_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic [7:0] vga_x_q, vga_x_d;
   logic [6:0] vga_y_q, vga_y_d;
   logic [2:0] vga_colour_q, vga_colour_d;
   logic       vga_plot_q, vga_plot_d;
   logic       clear_done_q, clear_done_d;

   logic       snake_win;
   logic       food_win;
   logic       sweep_last;
   logic [2:0] sweep_colour;

   // Round-robin grant decision; silent in reset, while clearing, and when a clear is being started.
   always_comb begin
      snake_win = 1'b0;
      food_win  = 1'b0;
      if (rst && (state_q == ST_RUN) && !clear_start) begin
         if (snake_req && food_req) begin
            if (last_grant_q == GRANT_FOOD) begin
               snake_win = 1'b1;
            end else begin
               food_win = 1'b1;
            end
         end else if (snake_req) begin
            snake_win = 1'b1;
         end else if (food_req) begin
            food_win = 1'b1;
         end
      end
   end

   assign snake_gnt = snake_win;
   assign food_gnt  = food_win;
   assign busy      = (state_q == ST_CLEAR);

   assign sweep_last = (cx_q == X_LAST) && (cy_q == Y_LAST);

   // Colour of the pixel the sweep issues this cycle.
   always_comb begin
      sweep_colour = BG_COLOUR;
`ifdef PLOT_BORDER_EN
      if ((cx_q == 8'd0) || (cx_q == X_LAST) || (cy_q == 7'd0) || (cy_q == Y_LAST)) begin
         sweep_colour = 3'b111;
      end
`else
      sweep_colour = BG_COLOUR;
`endif
   end

   // Next-state: mode transitions, sweep raster counters and the pixel presented to the adapter.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      clear_done_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (clear_start) begin
               state_d = ST_CLEAR;
               cx_d    = 8'd0;
               cy_d    = 7'd0;
            end else if (snake_win) begin
               vga_x_d      = snake_x;
               vga_y_d      = snake_y;
               vga_colour_d = snake_colour;
               vga_plot_d   = 1'b1;
               last_grant_d = GRANT_SNAKE;
            end else if (food_win) begin
               vga_x_d      = food_x;
               vga_y_d      = food_y;
               vga_colour_d = food_colour;
               vga_plot_d   = 1'b1;
               last_grant_d = GRANT_FOOD;
            end
         end
         ST_CLEAR: begin
            if (clear_start) begin
               // Abort: rewind to the origin; the new sweep's first pixel goes out next cycle.
               cx_d = 8'd0;
               cy_d = 7'd0;
            end else begin
               vga_x_d      = cx_q;
               vga_y_d      = cy_q;
               vga_colour_d = sweep_colour;
               vga_plot_d   = 1'b1;
               if (sweep_last) begin
                  state_d      = ST_RUN;
                  cx_d         = 8'd0;
                  cy_d         = 7'd0;
                  clear_done_d = 1'b1;
               end else if (cx_q == X_LAST) begin
                  cx_d = 8'd0;
                  cy_d = cy_q + 7'd1;
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, counters and all adapter-facing outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         last_grant_q <= GRANT_FOOD;
         cx_q         <= 8'd0;
         cy_q         <= 7'd0;
         vga_x_q      <= 8'd0;
         vga_y_q      <= 7'd0;
         vga_colour_q <= 3'd0;
         vga_plot_q   <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         clear_done_q <= clear_done_d;
      end
   end

   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign clear_done = clear_done_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: reset, single/contended grants, clear sweep, held request, restart.
module tb_plot_arbiter;

   logic       clk;
   logic       rst;
   logic       clear_start;
   logic       clear_done;
   logic       snake_req;
   logic [7:0] snake_x;
   logic [6:0] snake_y;
   logic [2:0] snake_colour;
   logic       snake_gnt;
   logic       food_req;
   logic [7:0] food_x;
   logic [6:0] food_y;
   logic [2:0] food_colour;
   logic       food_gnt;
   logic       busy;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int n_checks = 0;
   int n_fail   = 0;

   plot_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .clear_start  (clear_start),
      .clear_done   (clear_done),
      .snake_req    (snake_req),
      .snake_x      (snake_x),
      .snake_y      (snake_y),
      .snake_colour (snake_colour),
      .snake_gnt    (snake_gnt),
      .food_req     (food_req),
      .food_x       (food_x),
      .food_y       (food_y),
      .food_colour  (food_colour),
      .food_gnt     (food_gnt),
      .busy         (busy),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset;
      @(negedge clk);
      rst = 1'b0;
      clear_start = 1'b0;
      snake_req = 1'b0;
      food_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      clear_start = 1'($urandom);
      snake_req = 1'b1;
      food_req = 1'b1;
      snake_x = 8'($urandom); snake_y = 7'($urandom); snake_colour = 3'($urandom);
      food_x = 8'($urandom);  food_y = 7'($urandom);  food_colour = 3'($urandom);
      repeat (3) @(negedge clk);
      n_checks++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot got %b want 0", vga_plot); end
      n_checks++; if ({snake_gnt, food_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", {snake_gnt, food_gnt}); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin n_fail++; $display("FAIL reset_xyc got %0d,%0d,%0d want 0,0,0", vga_x, vga_y, vga_colour); end
      n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", clear_done); end
      // release with only snake requesting
      clear_start = 1'b0;
      food_req = 1'b0;
      snake_x = 8'd5; snake_y = 7'd6; snake_colour = 3'd1;
      rst = 1'b1;
      #1;
      n_checks++; if (snake_gnt !== 1'b1 || food_gnt !== 1'b0) begin n_fail++; $display("FAIL release_snake_gnt got %b%b want 10", snake_gnt, food_gnt); end
      @(negedge clk);
      snake_req = 1'b0;
      n_checks++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd5, 7'd6, 3'd1}) begin n_fail++; $display("FAIL release_pixel got %b %0d,%0d,%0d want 1 5,6,1", vga_plot, vga_x, vga_y, vga_colour); end
      #1;
      n_checks++; if (snake_gnt !== 1'b0) begin n_fail++; $display("FAIL gnt_drop got %b want 0", snake_gnt); end
      @(negedge clk);
      n_checks++; if (vga_plot !== 1'b0 || vga_x !== 8'd5) begin n_fail++; $display("FAIL idle_hold got plot %b x %0d want 0 5", vga_plot, vga_x); end
   endtask

   task automatic test_contention;
      apply_reset();
      snake_x = 8'd10; snake_y = 7'd20; snake_colour = 3'b010;
      food_x  = 8'd30; food_y  = 7'd40; food_colour  = 3'b100;
      snake_req = 1'b1;
      food_req = 1'b1;
      #1;
      n_checks++; if ({snake_gnt, food_gnt} !== 2'b10) begin n_fail++; $display("FAIL cont_g1 got %b want 10", {snake_gnt, food_gnt}); end
      @(negedge clk);
      n_checks++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd10, 7'd20, 3'b010}) begin n_fail++; $display("FAIL cont_p1 got %b %0d,%0d,%0d want 1 10,20,2", vga_plot, vga_x, vga_y, vga_colour); end
      n_checks++; if ({snake_gnt, food_gnt} !== 2'b01) begin n_fail++; $display("FAIL cont_g2 got %b want 01", {snake_gnt, food_gnt}); end
      @(negedge clk);
      n_checks++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd30, 7'd40, 3'b100}) begin n_fail++; $display("FAIL cont_p2 got %b %0d,%0d,%0d want 1 30,40,4", vga_plot, vga_x, vga_y, vga_colour); end
      n_checks++; if ({snake_gnt, food_gnt} !== 2'b10) begin n_fail++; $display("FAIL cont_g3 got %b want 10", {snake_gnt, food_gnt}); end
      snake_x = 8'd11;
      @(negedge clk);
      snake_req = 1'b0;
      food_req = 1'b0;
      n_checks++; if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd11, 7'd20}) begin n_fail++; $display("FAIL cont_p3 got %b %0d,%0d want 1 11,20", vga_plot, vga_x, vga_y); end
      @(negedge clk);
      n_checks++; if (vga_plot !== 1'b0 || vga_x !== 8'd11) begin n_fail++; $display("FAIL cont_idle got plot %b x %0d want 0 11", vga_plot, vga_x); end
   endtask

   task automatic test_clear_sweep;
      int busy_cnt = 0;
      int plot_cnt = 0;
      int done_cnt = 0;
      int done_at = 0;
      int gnt_in_clear = 0;
      int pix_err = 0;
      int k;
      clear_start = 1'b1;
      snake_req = 1'b0;
      food_req = 1'b0;
      @(negedge clk);
      clear_start = 1'b0;
      for (int i = 1; i <= 19201; i++) begin
         if (i > 1) @(negedge clk);
         if (busy) busy_cnt++;
         if (vga_plot) plot_cnt++;
         if (clear_done) begin done_cnt++; done_at = i; end
         if (busy && food_gnt) gnt_in_clear++;
         if (i >= 2) begin
            k = i - 2;
            if (vga_plot !== 1'b1 || vga_x !== 8'(k % 160) || vga_y !== 7'(k / 160)) pix_err++;
         end
         if (i == 2) begin
            n_checks++; if ({vga_x, vga_y} !== {8'd0, 7'd0}) begin n_fail++; $display("FAIL sweep_first got %0d,%0d want 0,0", vga_x, vga_y); end
         end
         if (i == 162) begin
            n_checks++; if ({vga_x, vga_y} !== {8'd0, 7'd1}) begin n_fail++; $display("FAIL sweep_px161 got %0d,%0d want 0,1", vga_x, vga_y); end
         end
`ifdef PLOT_BORDER_EN
         if (i == 2 + 50 * 160) begin
            n_checks++; if (vga_colour !== 3'b111) begin n_fail++; $display("FAIL border_0_50 got %b want 111", vga_colour); end
         end
         if (i == 2 + 159) begin
            n_checks++; if (vga_colour !== 3'b111) begin n_fail++; $display("FAIL border_159_0 got %b want 111", vga_colour); end
         end
         if (i == 2 + 119 * 160 + 80) begin
            n_checks++; if (vga_colour !== 3'b111) begin n_fail++; $display("FAIL border_80_119 got %b want 111", vga_colour); end
         end
`else
         if (i == 2 + 50 * 160) begin
            n_checks++; if (vga_colour !== 3'b000) begin n_fail++; $display("FAIL bg_0_50 got %b want 000", vga_colour); end
         end
`endif
         if (i == 2 + 60 * 160 + 80) begin
            n_checks++; if (vga_colour !== 3'b000) begin n_fail++; $display("FAIL bg_80_60 got %b want 000", vga_colour); end
         end
         if (i == 101) begin
            food_x = 8'd7; food_y = 7'd8; food_colour = 3'd5;
            food_req = 1'b1;
         end
      end
      n_checks++; if (busy_cnt != 19200) begin n_fail++; $display("FAIL sweep_busy_cycles got %0d want 19200", busy_cnt); end
      n_checks++; if (plot_cnt != 19200) begin n_fail++; $display("FAIL sweep_plot_cycles got %0d want 19200", plot_cnt); end
      n_checks++; if (pix_err != 0) begin n_fail++; $display("FAIL sweep_raster got %0d bad pixels want 0", pix_err); end
      n_checks++; if (done_cnt != 1 || done_at != 19201) begin n_fail++; $display("FAIL sweep_done got %0d pulses at %0d want 1 at 19201", done_cnt, done_at); end
      n_checks++; if ({vga_x, vga_y} !== {8'd159, 7'd119}) begin n_fail++; $display("FAIL sweep_last got %0d,%0d want 159,119", vga_x, vga_y); end
      n_checks++; if (gnt_in_clear != 0) begin n_fail++; $display("FAIL held_no_gnt got %0d grants want 0", gnt_in_clear); end
      n_checks++; if (busy !== 1'b0 || food_gnt !== 1'b1) begin n_fail++; $display("FAIL held_first_run got busy %b gnt %b want 0 1", busy, food_gnt); end
      @(negedge clk);
      food_req = 1'b0;
      n_checks++; if ({vga_plot, vga_x, vga_y, vga_colour, clear_done} !== {1'b1, 8'd7, 7'd8, 3'd5, 1'b0}) begin n_fail++; $display("FAIL held_pixel got %b %0d,%0d,%0d done %b want 1 7,8,5 0", vga_plot, vga_x, vga_y, vga_colour, clear_done); end
      @(negedge clk);
   endtask

   task automatic test_restart;
      int done_cnt = 0;
      int done_at = 0;
      int gnt_in_clear = 0;
      snake_x = 8'd50; snake_y = 7'd60; snake_colour = 3'd6;
      snake_req = 1'b1;
      clear_start = 1'b1;
      #1;
      n_checks++; if ({snake_gnt, food_gnt} !== 2'b00) begin n_fail++; $display("FAIL clear_wins got %b want 00", {snake_gnt, food_gnt}); end
      @(negedge clk);
      clear_start = 1'b0;
      for (int i = 1; i <= 24202; i++) begin
         if (i > 1) @(negedge clk);
         if (clear_done) begin done_cnt++; done_at = i; end
         if (busy && snake_gnt) gnt_in_clear++;
         if (i == 5001) clear_start = 1'b1;
         if (i == 5002) begin
            clear_start = 1'b0;
            n_checks++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL restart_gap got %b want 0", vga_plot); end
         end
         if (i == 5003) begin
            n_checks++; if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd0, 7'd0}) begin n_fail++; $display("FAIL restart_origin got %b %0d,%0d want 1 0,0", vga_plot, vga_x, vga_y); end
         end
      end
      n_checks++; if (done_cnt != 1 || done_at != 24202) begin n_fail++; $display("FAIL restart_done got %0d pulses at %0d want 1 at 24202", done_cnt, done_at); end
      n_checks++; if (gnt_in_clear != 0) begin n_fail++; $display("FAIL restart_no_gnt got %0d want 0", gnt_in_clear); end
      n_checks++; if (snake_gnt !== 1'b1) begin n_fail++; $display("FAIL restart_snake_gnt got %b want 1", snake_gnt); end
      @(negedge clk);
      snake_req = 1'b0;
      n_checks++; if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd50, 7'd60, 3'd6}) begin n_fail++; $display("FAIL restart_snake_px got %b %0d,%0d,%0d want 1 50,60,6", vga_plot, vga_x, vga_y, vga_colour); end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_contention();
      test_clear_sweep();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
